// File: rtl/ahb_dma_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_dma_port_arbiter
//  Purpose  : Two-master AHB-Lite arbiter in front of the single DMA slave
//             port. Each master's address phase is captured into a private
//             holding register. Held transfers are replayed one at a time,
//             non-pipelined, under round-robin or fixed-priority grant.
//  Revision : 1.0 - initial release
// ============================================================================
module ahb_dma_port_arbiter #(
    parameter int RR_ENABLE = 1   // 1: round-robin, 0: master 0 has priority
) (
    input  logic        clk,
    input  logic        reset_l,

    input  logic [31:0] m0_ahb_haddr,
    input  logic [2:0]  m0_ahb_hsize,
    input  logic [1:0]  m0_ahb_htrans,
    input  logic        m0_ahb_hwrite,
    input  logic [63:0] m0_ahb_hwdata,
    output logic [63:0] m0_ahb_hrdata,
    output logic        m0_ahb_hreadyout,
    output logic        m0_ahb_hresp,

    input  logic [31:0] m1_ahb_haddr,
    input  logic [2:0]  m1_ahb_hsize,
    input  logic [1:0]  m1_ahb_htrans,
    input  logic        m1_ahb_hwrite,
    input  logic [63:0] m1_ahb_hwdata,
    output logic [63:0] m1_ahb_hrdata,
    output logic        m1_ahb_hreadyout,
    output logic        m1_ahb_hresp,

    output logic [31:0] s_ahb_haddr,
    output logic [2:0]  s_ahb_hsize,
    output logic [1:0]  s_ahb_htrans,
    output logic        s_ahb_hwrite,
    output logic [63:0] s_ahb_hwdata,
    output logic [2:0]  s_ahb_hburst,
    output logic        s_ahb_hmastlock,
    output logic [3:0]  s_ahb_hprot,
    input  logic [63:0] s_ahb_hrdata,
    input  logic        s_ahb_hready,
    input  logic        s_ahb_hresp,

    output logic [1:0]  gnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    // Arbiter state
    logic [1:0]  state_q,     state_d;
    logic        sel_q,       sel_d;        // owner of the port: 0 = m0, 1 = m1
    logic        last_gnt_q,  last_gnt_d;   // master granted most recently

    // Per-master holding registers
    logic        pend0_q,     pend0_d;
    logic [31:0] haddr0_q,    haddr0_d;
    logic [2:0]  hsize0_q,    hsize0_d;
    logic        hwrite0_q,   hwrite0_d;
    logic        pend1_q,     pend1_d;
    logic [31:0] haddr1_q,    haddr1_d;
    logic [2:0]  hsize1_q,    hsize1_d;
    logic        hwrite1_q,   hwrite1_d;

    logic        w_busy;      // ADDR or DATA: port is owned
    logic        w_done0;     // completion cycle of an m0 transfer
    logic        w_done1;     // completion cycle of an m1 transfer
    logic        w_cap0;
    logic        w_cap1;
    logic        w_grant_m1;  // arbitration result used when leaving IDLE

    // Only htrans[1] distinguishes NONSEQ/SEQ from IDLE/BUSY
    logic        unused_htrans;
    assign unused_htrans = m0_ahb_htrans[0] ^ m1_ahb_htrans[0];

    assign w_busy  = (state_q == ST_ADDR) || (state_q == ST_DATA);
    assign w_done0 = (state_q == ST_DATA) && !sel_q && s_ahb_hready;
    assign w_done1 = (state_q == ST_DATA) &&  sel_q && s_ahb_hready;

    // A master is stalled while it has a held transfer, except that in its
    // completion cycle the slave's ready is passed straight through.
    assign m0_ahb_hreadyout = ((state_q == ST_DATA) && !sel_q) ? s_ahb_hready : !pend0_q;
    assign m1_ahb_hreadyout = ((state_q == ST_DATA) &&  sel_q) ? s_ahb_hready : !pend1_q;

    assign w_cap0 = m0_ahb_htrans[1] && m0_ahb_hreadyout;
    assign w_cap1 = m1_ahb_htrans[1] && m1_ahb_hreadyout;

    // On a tie round-robin picks the master not granted last time
    assign w_grant_m1 = pend1_q && (!pend0_q || ((RR_ENABLE != 0) && !last_gnt_q));

    // State register and holding registers
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            state_q    <= ST_IDLE;
            sel_q      <= 1'b0;
            last_gnt_q <= 1'b1;
            pend0_q    <= 1'b0;
            haddr0_q   <= 32'd0;
            hsize0_q   <= 3'd0;
            hwrite0_q  <= 1'b0;
            pend1_q    <= 1'b0;
            haddr1_q   <= 32'd0;
            hsize1_q   <= 3'd0;
            hwrite1_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            last_gnt_q <= last_gnt_d;
            pend0_q    <= pend0_d;
            haddr0_q   <= haddr0_d;
            hsize0_q   <= hsize0_d;
            hwrite0_q  <= hwrite0_d;
            pend1_q    <= pend1_d;
            haddr1_q   <= haddr1_d;
            hsize1_q   <= hsize1_d;
            hwrite1_q  <= hwrite1_d;
        end
    end

    // Capture new address phases; a capture in the completion cycle wins
    always_comb begin
        pend0_d   = pend0_q;
        haddr0_d  = haddr0_q;
        hsize0_d  = hsize0_q;
        hwrite0_d = hwrite0_q;
        pend1_d   = pend1_q;
        haddr1_d  = haddr1_q;
        hsize1_d  = hsize1_q;
        hwrite1_d = hwrite1_q;
        if (w_cap0) begin
            pend0_d   = 1'b1;
            haddr0_d  = m0_ahb_haddr;
            hsize0_d  = m0_ahb_hsize;
            hwrite0_d = m0_ahb_hwrite;
        end else if (w_done0) begin
            pend0_d   = 1'b0;
        end
        if (w_cap1) begin
            pend1_d   = 1'b1;
            haddr1_d  = m1_ahb_haddr;
            hsize1_d  = m1_ahb_hsize;
            hwrite1_d = m1_ahb_hwrite;
        end else if (w_done1) begin
            pend1_d   = 1'b0;
        end
    end

    // Next-state logic: grant from IDLE, advance on slave ready
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        last_gnt_d = last_gnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pend0_q || pend1_q) begin
                    sel_d      = w_grant_m1;
                    last_gnt_d = w_grant_m1;
                    state_d    = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (s_ahb_hready) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (s_ahb_hready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic: replay the owner's held fields and route the data phase
    always_comb begin
        s_ahb_htrans  = HTRANS_IDLE;
        s_ahb_haddr   = 32'd0;
        s_ahb_hsize   = 3'd0;
        s_ahb_hwrite  = 1'b0;
        s_ahb_hwdata  = 64'd0;
        gnt           = 2'b00;
        m0_ahb_hrdata = 64'd0;
        m0_ahb_hresp  = 1'b0;
        m1_ahb_hrdata = 64'd0;
        m1_ahb_hresp  = 1'b0;
        if (state_q == ST_ADDR) begin
            s_ahb_htrans = HTRANS_NONSEQ;
        end
        if (w_busy) begin
            gnt          = sel_q ? 2'b10 : 2'b01;
            s_ahb_haddr  = sel_q ? haddr1_q  : haddr0_q;
            s_ahb_hsize  = sel_q ? hsize1_q  : hsize0_q;
            s_ahb_hwrite = sel_q ? hwrite1_q : hwrite0_q;
        end
        if (state_q == ST_DATA) begin
            // The owner is stalled, so its live hwdata is stable here
            s_ahb_hwdata = sel_q ? m1_ahb_hwdata : m0_ahb_hwdata;
            if (sel_q) begin
                m1_ahb_hrdata = s_ahb_hrdata;
                m1_ahb_hresp  = s_ahb_hresp;
            end else begin
                m0_ahb_hrdata = s_ahb_hrdata;
                m0_ahb_hresp  = s_ahb_hresp;
            end
        end
    end

    assign s_ahb_hburst    = 3'b000;
    assign s_ahb_hmastlock = 1'b0;
    assign s_ahb_hprot     = 4'b0011;

endmodule
`default_nettype wire

// File: tb/tb_ahb_dma_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ahb_dma_port_arbiter
//  Purpose  : Cycle-vector bench for ahb_dma_port_arbiter. A round-robin and
//             a fixed-priority instance share the stimulus; each vector says
//             which instance it checks. Address phases seen on the DMA port
//             are also matched against per-master queues of issued requests.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_dma_port_arbiter;

    localparam logic [63:0] M0WD = 64'hA5A5_0000_1234_5678;
    localparam logic [63:0] M1WD = 64'hDEAD_BEEF_0000_0001;
    localparam logic [63:0] SRD  = 64'h1122_3344_5566_7788;
    localparam logic [1:0]  ID = 2'b00, BZ = 2'b01, NS = 2'b10, SQ = 2'b11;

    typedef struct {
        logic       rst_l;
        logic [1:0] t0;  logic w0;
        logic [1:0] t1;  logic w1;
        logic       rdy; logic err;
        logic       fp;                  // check the fixed-priority instance
        logic [1:0] e_gnt; logic [1:0] e_str;
        logic       e_r0;  logic e_r1;
        logic       e_e0;  logic e_e1;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
    } sb_t;

    logic        clk = 1'b0;
    logic        reset_l = 1'b0;
    logic [31:0] m0_haddr = 32'hBAD0_0000, m1_haddr = 32'hBAD1_0000;
    logic [2:0]  m0_hsize = 3'd2, m1_hsize = 3'd3;
    logic [1:0]  m0_htrans = ID, m1_htrans = ID;
    logic        m0_hwrite = 1'b0, m1_hwrite = 1'b0;
    logic [63:0] m0_hwdata = M0WD, m1_hwdata = M1WD;
    logic [63:0] s_hrdata = SRD;
    logic        s_hready = 1'b1, s_hresp = 1'b0;

    logic [63:0] rr_m0_hrdata, rr_m1_hrdata, fp_m0_hrdata, fp_m1_hrdata;
    logic        rr_m0_rdy, rr_m1_rdy, fp_m0_rdy, fp_m1_rdy;
    logic        rr_m0_resp, rr_m1_resp, fp_m0_resp, fp_m1_resp;
    logic [31:0] rr_s_haddr, fp_s_haddr;
    logic [2:0]  rr_s_hsize, fp_s_hsize, rr_s_hburst, fp_s_hburst;
    logic [1:0]  rr_s_htrans, fp_s_htrans, rr_gnt, fp_gnt;
    logic        rr_s_hwrite, fp_s_hwrite, rr_s_hmastlock, fp_s_hmastlock;
    logic [63:0] rr_s_hwdata, fp_s_hwdata;
    logic [3:0]  rr_s_hprot, fp_s_hprot;

    int n_cmp = 0;
    int n_bad = 0;
    int cur_idx = -1;
    logic sb_on = 1'b0;
    sb_t q0[$];
    sb_t q1[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    ahb_dma_port_arbiter #(.RR_ENABLE(1)) u_rr (
        .clk(clk), .reset_l(reset_l),
        .m0_ahb_haddr(m0_haddr), .m0_ahb_hsize(m0_hsize), .m0_ahb_htrans(m0_htrans),
        .m0_ahb_hwrite(m0_hwrite), .m0_ahb_hwdata(m0_hwdata), .m0_ahb_hrdata(rr_m0_hrdata),
        .m0_ahb_hreadyout(rr_m0_rdy), .m0_ahb_hresp(rr_m0_resp),
        .m1_ahb_haddr(m1_haddr), .m1_ahb_hsize(m1_hsize), .m1_ahb_htrans(m1_htrans),
        .m1_ahb_hwrite(m1_hwrite), .m1_ahb_hwdata(m1_hwdata), .m1_ahb_hrdata(rr_m1_hrdata),
        .m1_ahb_hreadyout(rr_m1_rdy), .m1_ahb_hresp(rr_m1_resp),
        .s_ahb_haddr(rr_s_haddr), .s_ahb_hsize(rr_s_hsize), .s_ahb_htrans(rr_s_htrans),
        .s_ahb_hwrite(rr_s_hwrite), .s_ahb_hwdata(rr_s_hwdata), .s_ahb_hburst(rr_s_hburst),
        .s_ahb_hmastlock(rr_s_hmastlock), .s_ahb_hprot(rr_s_hprot),
        .s_ahb_hrdata(s_hrdata), .s_ahb_hready(s_hready), .s_ahb_hresp(s_hresp),
        .gnt(rr_gnt)
    );

    ahb_dma_port_arbiter #(.RR_ENABLE(0)) u_fp (
        .clk(clk), .reset_l(reset_l),
        .m0_ahb_haddr(m0_haddr), .m0_ahb_hsize(m0_hsize), .m0_ahb_htrans(m0_htrans),
        .m0_ahb_hwrite(m0_hwrite), .m0_ahb_hwdata(m0_hwdata), .m0_ahb_hrdata(fp_m0_hrdata),
        .m0_ahb_hreadyout(fp_m0_rdy), .m0_ahb_hresp(fp_m0_resp),
        .m1_ahb_haddr(m1_haddr), .m1_ahb_hsize(m1_hsize), .m1_ahb_htrans(m1_htrans),
        .m1_ahb_hwrite(m1_hwrite), .m1_ahb_hwdata(m1_hwdata), .m1_ahb_hrdata(fp_m1_hrdata),
        .m1_ahb_hreadyout(fp_m1_rdy), .m1_ahb_hresp(fp_m1_resp),
        .s_ahb_haddr(fp_s_haddr), .s_ahb_hsize(fp_s_hsize), .s_ahb_htrans(fp_s_htrans),
        .s_ahb_hwrite(fp_s_hwrite), .s_ahb_hwdata(fp_s_hwdata), .s_ahb_hburst(fp_s_hburst),
        .s_ahb_hmastlock(fp_s_hmastlock), .s_ahb_hprot(fp_s_hprot),
        .s_ahb_hrdata(s_hrdata), .s_ahb_hready(s_hready), .s_ahb_hresp(s_hresp),
        .gnt(fp_gnt)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s vec=%0d t=%0t got=%h want=%h", nm, cur_idx, $time, act, exp);
        end
    endtask

    function automatic vec_t V(input logic rst, input logic [1:0] t0, input logic w0,
                               input logic [1:0] t1, input logic w1,
                               input logic rdy, input logic err, input logic fp,
                               input logic [1:0] g, input logic [1:0] st,
                               input logic r0, input logic r1,
                               input logic e0, input logic e1);
        vec_t v;
        v.rst_l = rst; v.t0 = t0; v.w0 = w0; v.t1 = t1; v.w1 = w1;
        v.rdy = rdy; v.err = err; v.fp = fp; v.e_gnt = g; v.e_str = st;
        v.e_r0 = r0; v.e_r1 = r1; v.e_e0 = e0; v.e_e1 = e1;
        return v;
    endfunction

    // Address phases accepted by the round-robin port, matched to requests
    always @(negedge clk) begin
        if (sb_on && rr_s_htrans == NS && s_hready) begin
            sb_t e;
            e.addr = 32'd0; e.wr = 1'b0; e.size = 3'd0;
            if (rr_gnt == 2'b01 && q0.size() != 0) e = q0.pop_front();
            else if (rr_gnt == 2'b10 && q1.size() != 0) e = q1.pop_front();
            chk("sb_addr_phase", 64'({rr_s_haddr, rr_s_hwrite, rr_s_hsize}),
                64'({e.addr, e.wr, e.size}));
        end
    end

    initial begin
        logic [31:0] held_a [2];
        logic        held_w [2];
        logic [31:0] a_next [2];
        logic [1:0]  g;
        logic [1:0]  ag, ast;
        logic        ar0, ar1, ae0, ae1, awr;
        logic [31:0] aad;
        logic [2:0]  asz;
        logic [63:0] awd, ard0, ard1;
        logic [7:0]  atie;
        vec_t v;

        held_a[0] = 32'd0; held_a[1] = 32'd0; held_w[0] = 1'b0; held_w[1] = 1'b0;
        a_next[0] = 32'h0000_1000; a_next[1] = 32'h0000_2008;

        // Reset with m0 requesting: capture must be suppressed
        tbl.push_back(V(0, NS,0, ID,0, 1,0, 0, 2'b00,ID, 1,1, 0,0));
        // Single read by m0, m1 BUSY ignored
        tbl.push_back(V(1, NS,0, BZ,0, 1,0, 0, 2'b00,ID, 1,1, 0,0));
        tbl.push_back(V(1, ID,0, ID,0, 1,0, 0, 2'b00,ID, 0,1, 0,0));
        tbl.push_back(V(1, ID,0, ID,0, 1,0, 0, 2'b01,NS, 0,1, 0,0));
        tbl.push_back(V(1, ID,0, ID,0, 1,0, 0, 2'b01,ID, 1,1, 0,0));
        // m1 write, three DATA wait states
        tbl.push_back(V(1, ID,0, NS,1, 1,0, 0, 2'b00,ID, 1,1, 0,0));
        tbl.push_back(V(1, ID,0, ID,0, 1,0, 0, 2'b00,ID, 1,0, 0,0));
        tbl.push_back(V(1, ID,0, ID,0, 1,0, 0, 2'b10,NS, 1,0, 0,0));
        for (int k = 0; k < 3; k++)
            tbl.push_back(V(1, ID,0, ID,0, 0,0, 0, 2'b10,ID, 1,0, 0,0));
        tbl.push_back(V(1, ID,0, ID,0, 1,0, 0, 2'b10,ID, 1,1, 0,0));
        // Four simultaneous requests, each served m0 then m1
        for (int k = 0; k < 4; k++) begin
            tbl.push_back(V(1, NS,k[0], (k[0] ? SQ : NS),!k[0], 1,0, 0, 2'b00,ID, 1,1, 0,0));
            tbl.push_back(V(1, ID,0, ID,0, 1,0, 0, 2'b00,ID, 0,0, 0,0));
            tbl.push_back(V(1, ID,0, ID,0, 1,0, 0, 2'b01,NS, 0,0, 0,0));
            tbl.push_back(V(1, ID,0, ID,0, 1,0, 0, 2'b01,ID, 1,0, 0,0));
            tbl.push_back(V(1, ID,0, ID,0, 1,0, 0, 2'b00,ID, 1,0, 0,0));
            tbl.push_back(V(1, ID,0, ID,0, 1,0, 0, 2'b10,NS, 1,0, 0,0));
            tbl.push_back(V(1, ID,0, ID,0, 1,0, 0, 2'b10,ID, 1,1, 0,0));
        end
        // Two-cycle error on an m0 read, then a normal m0 read
        tbl.push_back(V(1, NS,0, ID,0, 1,0, 0, 2'b00,ID, 1,1, 0,0));
        tbl.push_back(V(1, ID,0, ID,0, 1,0, 0, 2'b00,ID, 0,1, 0,0));
        tbl.push_back(V(1, ID,0, ID,0, 1,1, 0, 2'b01,NS, 0,1, 0,0));
        tbl.push_back(V(1, ID,0, ID,0, 0,1, 0, 2'b01,ID, 0,1, 1,0));
        tbl.push_back(V(1, ID,0, ID,0, 1,1, 0, 2'b01,ID, 1,1, 1,0));
        tbl.push_back(V(1, NS,0, ID,0, 1,0, 0, 2'b00,ID, 1,1, 0,0));
        tbl.push_back(V(1, ID,0, ID,0, 1,0, 0, 2'b00,ID, 0,1, 0,0));
        tbl.push_back(V(1, ID,0, ID,0, 1,0, 0, 2'b01,NS, 0,1, 0,0));
        tbl.push_back(V(1, ID,0, ID,0, 1,0, 0, 2'b01,ID, 1,1, 0,0));
        // Tie with m0 granted last: m1 wins; m1 recaptures; next tie goes to m0
        tbl.push_back(V(1, NS,1, NS,0, 1,0, 0, 2'b00,ID, 1,1, 0,0));
        tbl.push_back(V(1, ID,0, ID,0, 1,0, 0, 2'b00,ID, 0,0, 0,0));
        tbl.push_back(V(1, ID,0, ID,0, 1,0, 0, 2'b10,NS, 0,0, 0,0));
        tbl.push_back(V(1, ID,0, NS,1, 1,0, 0, 2'b10,ID, 0,1, 0,0));
        tbl.push_back(V(1, ID,0, ID,0, 1,0, 0, 2'b00,ID, 0,0, 0,0));
        tbl.push_back(V(1, ID,0, ID,0, 1,0, 0, 2'b01,NS, 0,0, 0,0));
        tbl.push_back(V(1, ID,0, ID,0, 1,0, 0, 2'b01,ID, 1,0, 0,0));
        tbl.push_back(V(1, ID,0, ID,0, 1,0, 0, 2'b00,ID, 1,0, 0,0));
        tbl.push_back(V(1, ID,0, ID,0, 1,0, 0, 2'b10,NS, 1,0, 0,0));
        tbl.push_back(V(1, ID,0, ID,0, 1,0, 0, 2'b10,ID, 1,1, 0,0));
        tbl.push_back(V(0, ID,0, ID,0, 1,0, 0, 2'b00,ID, 1,1, 0,0));
        // Reset during m1's DATA phase, then a fresh m0 read
        tbl.push_back(V(1, ID,0, NS,1, 1,0, 0, 2'b00,ID, 1,1, 0,0));
        tbl.push_back(V(1, ID,0, ID,0, 1,0, 0, 2'b00,ID, 1,0, 0,0));
        tbl.push_back(V(1, ID,0, ID,0, 1,0, 0, 2'b10,NS, 1,0, 0,0));
        tbl.push_back(V(0, ID,0, ID,0, 0,0, 0, 2'b10,ID, 1,0, 0,0));
        tbl.push_back(V(1, NS,0, ID,0, 1,0, 0, 2'b00,ID, 1,1, 0,0));
        tbl.push_back(V(1, ID,0, ID,0, 1,0, 0, 2'b00,ID, 0,1, 0,0));
        tbl.push_back(V(1, ID,0, ID,0, 1,0, 0, 2'b01,NS, 0,1, 0,0));
        tbl.push_back(V(1, ID,0, ID,0, 1,0, 0, 2'b01,ID, 1,1, 0,0));
        // Fixed priority: m0 re-requests in every completion, m1 waits
        tbl.push_back(V(0, ID,0, ID,0, 1,0, 1, 2'b00,ID, 1,1, 0,0));
        tbl.push_back(V(1, NS,0, NS,1, 1,0, 1, 2'b00,ID, 1,1, 0,0));
        tbl.push_back(V(1, ID,0, ID,0, 1,0, 1, 2'b00,ID, 0,0, 0,0));
        for (int k = 0; k < 3; k++) begin
            tbl.push_back(V(1, ID,0, ID,0, 1,0, 1, 2'b01,NS, 0,0, 0,0));
            tbl.push_back(V(1, (k < 2) ? NS : ID,1, ID,0, 1,0, 1, 2'b01,ID, 1,0, 0,0));
            tbl.push_back(V(1, ID,0, ID,0, 1,0, 1, 2'b00,ID, (k < 2) ? 1'b0 : 1'b1,0, 0,0));
        end
        tbl.push_back(V(1, ID,0, ID,0, 1,0, 1, 2'b10,NS, 1,0, 0,0));
        tbl.push_back(V(1, ID,0, ID,0, 1,0, 1, 2'b10,ID, 1,1, 0,0));
        tbl.push_back(V(1, ID,0, ID,0, 1,0, 1, 2'b00,ID, 1,1, 0,0));

        repeat (3) @(posedge clk);

        foreach (tbl[i]) begin
            v = tbl[i];
            @(posedge clk);
            #1;
            cur_idx   = i;
            sb_on     = !v.fp;
            reset_l   = v.rst_l;
            s_hready  = v.rdy;
            s_hresp   = v.err;
            m0_htrans = v.t0; m0_hwrite = v.w0;
            m1_htrans = v.t1; m1_hwrite = v.w1;
            m0_haddr  = v.t0[1] ? a_next[0] : 32'hBAD0_0000;
            m1_haddr  = v.t1[1] ? a_next[1] : 32'hBAD1_0000;
            if (sb_on && v.rst_l && v.t0[1] && v.e_r0) q0.push_back('{a_next[0], v.w0, 3'd2});
            if (sb_on && v.rst_l && v.t1[1] && v.e_r1) q1.push_back('{a_next[1], v.w1, 3'd3});

            @(negedge clk);
            if (v.fp) begin
                ag = fp_gnt; ast = fp_s_htrans; ar0 = fp_m0_rdy; ar1 = fp_m1_rdy;
                ae0 = fp_m0_resp; ae1 = fp_m1_resp; aad = fp_s_haddr; asz = fp_s_hsize;
                awr = fp_s_hwrite; awd = fp_s_hwdata; ard0 = fp_m0_hrdata; ard1 = fp_m1_hrdata;
                atie = {fp_s_hburst, fp_s_hmastlock, fp_s_hprot};
            end else begin
                ag = rr_gnt; ast = rr_s_htrans; ar0 = rr_m0_rdy; ar1 = rr_m1_rdy;
                ae0 = rr_m0_resp; ae1 = rr_m1_resp; aad = rr_s_haddr; asz = rr_s_hsize;
                awr = rr_s_hwrite; awd = rr_s_hwdata; ard0 = rr_m0_hrdata; ard1 = rr_m1_hrdata;
                atie = {rr_s_hburst, rr_s_hmastlock, rr_s_hprot};
            end
            g = v.e_gnt;
            chk("ctrl{gnt,htrans,rdy0,rdy1,resp0,resp1}",
                64'({ag, ast, ar0, ar1, ae0, ae1}),
                64'({g, v.e_str, v.e_r0, v.e_r1, v.e_e0, v.e_e1}));
            chk("s_haddr_hwrite", 64'({aad, awr}),
                64'({(g == 2'b01) ? held_a[0] : (g == 2'b10) ? held_a[1] : 32'd0,
                     (g == 2'b01) ? held_w[0] : (g == 2'b10) ? held_w[1] : 1'b0}));
            chk("s_hsize", 64'(asz), (g == 2'b01) ? 64'd2 : (g == 2'b10) ? 64'd3 : 64'd0);
            chk("s_hwdata", awd, (v.e_str == ID && g == 2'b01) ? M0WD :
                                 (v.e_str == ID && g == 2'b10) ? M1WD : 64'd0);
            chk("m0_hrdata", ard0, (v.e_str == ID && g == 2'b01) ? SRD : 64'd0);
            chk("m1_hrdata", ard1, (v.e_str == ID && g == 2'b10) ? SRD : 64'd0);
            chk("tied_outputs", 64'(atie), 64'h03);

            if (v.rst_l && v.t0[1] && v.e_r0) begin
                held_a[0] = a_next[0]; held_w[0] = v.w0; a_next[0] = a_next[0] + 32'h10;
            end
            if (v.rst_l && v.t1[1] && v.e_r1) begin
                held_a[1] = a_next[1]; held_w[1] = v.w1; a_next[1] = a_next[1] + 32'h10;
            end
        end

        cur_idx = -1;
        chk("sb_unmatched_requests", 64'(q0.size() + q1.size()), 64'd0);
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ahb_dma_port_arbiter.md
# ahb_dma_port_arbiter

Two-master AHB-Lite arbiter that shares the single VeeR DMA AHB slave port between the LSU-to-DMA bridge path (master 0) and a testbench DMA traffic master (master 1). Each master sees a private AHB-Lite slave interface with its own `hreadyout`. Accepted address phases are held in per-master holding registers. Transfers are replayed one at a time, non-pipelined, onto the DMA port, under round-robin or fixed-priority grant.

## Interface
Parameters:
- `RR_ENABLE`, 1: 1 = round-robin between masters; 0 = fixed priority, master 0 wins.

Ports:
- `clk`  in  1  single clock.
- `reset_l`  in  1  synchronous, active-low reset.
- `mN_ahb_haddr`  in  32  master N address, N = 0, 1.
- `mN_ahb_hsize`  in  3  master N transfer size.
- `mN_ahb_htrans`  in  2  master N transfer type.
- `mN_ahb_hwrite`  in  1  master N write.
- `mN_ahb_hwdata`  in  64  master N write data, data phase.
- `mN_ahb_hrdata`  out  64  read data to master N.
- `mN_ahb_hreadyout`  out  1  ready to master N.
- `mN_ahb_hresp`  out  1  error response to master N.
- `s_ahb_haddr`  out  32  DMA port address.
- `s_ahb_hsize`  out  3  DMA port transfer size.
- `s_ahb_htrans`  out  2  DMA port transfer type: 2'b00 or 2'b10 only.
- `s_ahb_hwrite`  out  1  DMA port write.
- `s_ahb_hwdata`  out  64  DMA port write data.
- `s_ahb_hburst`  out  3  tied 0.
- `s_ahb_hmastlock`  out  1  tied 0.
- `s_ahb_hprot`  out  4  tied 4'b0011.
- `s_ahb_hrdata`  in  64  DMA port read data.
- `s_ahb_hready`  in  1  DMA port `hreadyout`.
- `s_ahb_hresp`  in  1  DMA port error response.
- `gnt`  out  2  one-hot owner of the DMA port; 0 when in IDLE.

## Operation
- Per-master holding register {haddr, hsize, hwrite} plus `pendN` flag.
- Capture: at a clock edge where `mN_ahb_htrans[1]` = 1 and `mN_ahb_hreadyout` = 1, load the holding register and set `pendN`.
- SEQ is treated as NONSEQ. BUSY and IDLE are ignored.
- Master ready: `mN_ahb_hreadyout` = !`pendN`, except in the completion cycle of master N's transfer, where it equals `s_ahb_hready`.
- State machine: IDLE, ADDR, DATA.
  - IDLE, one pend set: grant that master, go to ADDR.
  - IDLE, both pend set: RR_ENABLE = 1 grants the master that is not `last_gnt`; RR_ENABLE = 0 grants master 0.
  - On grant, `last_gnt` is updated to the granted master.
  - ADDR: drive the granted master's held fields with `s_ahb_htrans` = 2'b10. When `s_ahb_hready` = 1 go to DATA; otherwise hold.
  - DATA: `s_ahb_htrans` = 2'b00. `s_ahb_hwdata` = granted master's live `hwdata`; this is stable because that master is stalled.
  - DATA: `mN_ahb_hresp` = `s_ahb_hresp` and `mN_ahb_hrdata` = `s_ahb_hrdata` for the granted master.
  - DATA completion, `s_ahb_hready` = 1: clear `pendN` and go to IDLE.
- Completion vs. recapture: if master N issues a new NONSEQ in its completion cycle, the capture wins and `pendN` stays set.
- Error passthrough: a two-cycle DMA error (hresp=1/hready=0, then hresp=1/hready=1) passes through unchanged; the arbiter does not retry.
- Non-granted master: hrdata = 0, hresp = 0.
- Idle outputs: `s_ahb_haddr`, `s_ahb_hsize`, `s_ahb_hwrite`, `s_ahb_hwdata` are 0 outside ADDR/DATA, except hwdata, which follows the grant in DATA.

## Timing
- Reset values: state IDLE, pend0 = pend1 = 0, `last_gnt` = master 1 (master 0 wins the first tie).
- Outputs under reset: `s_ahb_htrans` 0, `s_ahb_haddr`/`hsize`/`hwrite`/`hwdata` 0, `mN_ahb_hreadyout` 1, `mN_ahb_hresp` 0, `mN_ahb_hrdata` 0, `gnt` 0.
- Reset asserted mid-transfer: the next cycle shows reset values. The in-flight DMA data phase is abandoned; the bench must not check its result.
- Minimum latency, master NONSEQ at cycle T with zero-wait slave:
  - T+1: pend set, hreadyout = 0, FSM IDLE.
  - T+2: ADDR.
  - T+3: DATA, completion; master hreadyout = 1.
- Result: 2 stall cycles per transfer at minimum.
- Back-to-back from one master with the other idle: one transfer per 3 cycles.
- Simultaneous captures at the same edge: both pend set; grant order is decided by `last_gnt`. The loser waits at least 3 more cycles.
- Slave wait states: `s_ahb_hready` low in ADDR or DATA extends that state one cycle per low cycle.

## Test plan
- Single read, master 0: m0 reads 0x0000_1000, slave returns 0x1122_3344_5566_7788 with zero wait -> m0 hreadyout low for exactly 2 cycles; hrdata correct on the completion cycle; `gnt` = 2'b01 for 2 cycles.
- Write with wait states: m1 writes 0xDEAD_BEEF_0000_0001 to 0x0000_2008, hsize 3; slave hready low for 3 cycles in DATA -> s_hwdata equals m1 hwdata through all DATA cycles; m1 hreadyout low for 5 cycles.
- Collision, RR_ENABLE = 1: m0 and m1 NONSEQ at the same edge, repeated 4 times -> grants alternate m0, m1, m0, m1 after reset; no lost transfers.
- Fixed priority, RR_ENABLE = 0: continuous m0 traffic plus one m1 request -> m0 always granted while pend0 is set; m1 is served in the first IDLE where pend0 = 0.
- Error: slave returns the two-cycle error on an m0 read -> m0 sees hresp = 1 with hreadyout = 0, then hresp = 1 with hreadyout = 1; pend0 cleared; next transfer proceeds normally.
- Reset mid-operation: reset_l low during m1's DATA -> next cycle: gnt = 0, s_htrans = 0, both hreadyout = 1; a new m0 read after release completes normally.
